axi_mem_responder: RTL and testbench

//  AXI4 responder backed by an internal word-addressed RAM. It sits on the memory end of the

---
 rtl/axi_mem_responder_if.sv | 74 +++++++
 rtl/axi_mem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a master and the axi_mem_responder memory model.
// Sideband lock/cache/prot/size/burst are carried so the slave can accept them.
interface axi_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) ();
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word-addressed RAM; serves one full-width INCR burst at a time.
// Reads go through a 1-cycle RAM register and a 2-entry output buffer (output reg + skid).
module axi_mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 8,
  parameter int MEM_WORDS_LOG2 = 12
) (
  input  logic                aclk,
  input  logic                reset,
  axi_mem_responder_if.slave  s_axi
);
  localparam int ALSB  = $clog2(STRB_WIDTH);
  localparam int IDXW  = MEM_WORDS_LOG2;
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WRESP = 2'd2,
    S_READ  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d, rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, skid_data_q, skid_data_d;
  logic [IDXW-1:0]       base_q, base_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic                  err_q, err_d, prio_rd_q, prio_rd_d;
  logic                  rd_pend_q, rd_pend_d, pend_last_q, pend_last_d, rd_all_q, rd_all_d;
  logic                  skid_v_q, skid_v_d, skid_last_q, skid_last_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  logic [IDXW-1:0]       beat_idx_s;
  logic                  mem_we_s, rd_en_s, pop_s, can_issue_s, wlast_err_s;
  logic [2:0]            occ_s;
  logic [ADDR_WIDTH-1:0] unused_addr_s;
  logic                  unused_s;

  assign beat_idx_s  = base_q + IDXW'(cnt_q);
  assign pop_s       = rvalid_q && s_axi.rready;
  assign wlast_err_s = (s_axi.wlast != (cnt_q == len_q));
  // Issue a RAM read only if its data is guaranteed a slot when it lands.
  assign occ_s       = {2'b00, rvalid_q} + {2'b00, skid_v_q} + {2'b00, rd_pend_q};
  assign can_issue_s = (occ_s + 3'd1) <= (3'd2 + {2'b00, pop_s});

  assign unused_addr_s = s_axi.awaddr ^ s_axi.araddr;
  assign unused_s = ^{unused_addr_s, s_axi.awsize, s_axi.awburst, s_axi.awlock, s_axi.awcache,
                      s_axi.awprot, s_axi.arsize, s_axi.arburst, s_axi.arlock, s_axi.arcache,
                      s_axi.arprot};

  assign s_axi.awready = awready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = 2'b00;

  // Next-state and next-output logic for arbitration, write, response and read flow.
  always_comb begin
    state_d     = state_q;     awready_d   = awready_q;   arready_d   = arready_q;
    wready_d    = wready_q;    bvalid_d    = bvalid_q;    bresp_d     = bresp_q;
    bid_d       = bid_q;       rid_d       = rid_q;       rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;     rdata_d     = rdata_q;     base_d      = base_q;
    len_d       = len_q;       cnt_d       = cnt_q;       err_d       = err_q;
    prio_rd_d   = prio_rd_q;   rd_pend_d   = 1'b0;        pend_last_d = pend_last_q;
    rd_all_d    = rd_all_q;    skid_v_d    = skid_v_q;    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q; mem_we_s    = 1'b0;        rd_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (awready_q) begin
          awready_d = 1'b0;
          if (s_axi.awvalid) begin
            bid_d    = s_axi.awid;
            base_d   = s_axi.awaddr[ALSB +: IDXW];
            len_d    = s_axi.awlen;
            cnt_d    = 8'd0;
            err_d    = 1'b0;
            wready_d = 1'b1;
            state_d  = S_WRITE;
          end else begin
            state_d  = S_IDLE;
          end
        end else if (arready_q) begin
          arready_d = 1'b0;
          if (s_axi.arvalid) begin
            rid_d    = s_axi.arid;
            base_d   = s_axi.araddr[ALSB +: IDXW];
            len_d    = s_axi.arlen;
            cnt_d    = 8'd0;
            rd_all_d = 1'b0;
            state_d  = S_READ;
          end else begin
            state_d  = S_IDLE;
          end
        end else if (s_axi.awvalid && s_axi.arvalid) begin
          awready_d = !prio_rd_q;
          arready_d = prio_rd_q;
          prio_rd_d = !prio_rd_q;
        end else if (s_axi.awvalid) begin
          awready_d = 1'b1;
        end else if (s_axi.arvalid) begin
          arready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (s_axi.wvalid) begin
          mem_we_s = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          err_d    = err_q || wlast_err_s;
          if (cnt_q == len_q) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || wlast_err_s) ? 2'b10 : 2'b00;
            state_d  = S_WRESP;
          end else begin
            state_d  = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRESP: begin
        if (s_axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_WRESP;
        end
      end
      S_READ: begin
        if (!rd_all_q && can_issue_s) begin
          rd_en_s     = 1'b1;
          rd_pend_d   = 1'b1;
          pend_last_d = (cnt_q == len_q);
          rd_all_d    = (cnt_q == len_q);
          cnt_d       = cnt_q + 8'd1;
        end else begin
          rd_en_s     = 1'b0;
        end
        // Skid entry is older than the RAM register, so it drains first.
        if (pop_s || !rvalid_q) begin
          if (skid_v_q) begin
            rvalid_d    = 1'b1;
            rdata_d     = skid_data_q;
            rlast_d     = skid_last_q;
            skid_v_d    = rd_pend_q;
            skid_data_d = rd_pend_q ? ram_rdata_q : skid_data_q;
            skid_last_d = rd_pend_q ? pend_last_q : skid_last_q;
          end else if (rd_pend_q) begin
            rvalid_d = 1'b1;
            rdata_d  = ram_rdata_q;
            rlast_d  = pend_last_q;
          end else begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end
        end else if (rd_pend_q) begin
          skid_v_d    = 1'b1;
          skid_data_d = ram_rdata_q;
          skid_last_d = pend_last_q;
        end else begin
          skid_v_d    = skid_v_q;
        end
        if (pop_s && rlast_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset; RAM is not touched here.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= S_IDLE; awready_q   <= 1'b0;   arready_q   <= 1'b0;
      wready_q    <= 1'b0;   bvalid_q    <= 1'b0;   bresp_q     <= 2'b00;
      bid_q       <= '0;     rid_q       <= '0;     rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;   rdata_q     <= '0;     base_q      <= '0;
      len_q       <= 8'd0;   cnt_q       <= 8'd0;   err_q       <= 1'b0;
      prio_rd_q   <= 1'b0;   rd_pend_q   <= 1'b0;   pend_last_q <= 1'b0;
      rd_all_q    <= 1'b0;   skid_v_q    <= 1'b0;   skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;     awready_q   <= awready_d;   arready_q   <= arready_d;
      wready_q    <= wready_d;    bvalid_q    <= bvalid_d;    bresp_q     <= bresp_d;
      bid_q       <= bid_d;       rid_q       <= rid_d;       rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;     rdata_q     <= rdata_d;     base_q      <= base_d;
      len_q       <= len_d;       cnt_q       <= cnt_d;       err_q       <= err_d;
      prio_rd_q   <= prio_rd_d;   rd_pend_q   <= rd_pend_d;   pend_last_q <= pend_last_d;
      rd_all_q    <= rd_all_d;    skid_v_q    <= skid_v_d;    skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end

  // Byte-masked RAM write port and registered read port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we_s && !reset) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.wstrb[b]) begin
          mem_q[beat_idx_s][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
    if (rd_en_s) begin
      ram_rdata_q <= mem_q[beat_idx_s];
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder: bursts, strobes, backpressure,
// arbitration, SLVERR on wlast mismatch, index wrap and mid-burst reset.
module tb_axi_mem_responder;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rd_buf [16];
  int          n_beats, rlast_err, stable_err, rd_lat;
  logic [7:0]  first_rid;
  logic [1:0]  b_resp;
  logic [7:0]  b_id;

  axi_mem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8)) ifc ();

  axi_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .ID_WIDTH(8), .MEM_WORDS_LOG2(12)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .s_axi (ifc.slave)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    int n = 0;
    ifc.awaddr = addr; ifc.awlen = len; ifc.awid = id; ifc.awvalid = 1'b1;
    while (ifc.awready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("aw_ready_timeout", ifc.awready, 1'b1);
    step();
    ifc.awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    int n = 0;
    ifc.araddr = addr; ifc.arlen = len; ifc.arid = id; ifc.arvalid = 1'b1;
    while (ifc.arready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("ar_ready_timeout", ifc.arready, 1'b1);
    step();
    ifc.arvalid = 1'b0;
  endtask

  task automatic w_send(input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      ifc.wdata = wdat[i]; ifc.wstrb = wstb[i]; ifc.wlast = (i == last_at); ifc.wvalid = 1'b1;
      while (ifc.wready !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) check_eq("w_ready_timeout", ifc.wready, 1'b1);
      step();
    end
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
  endtask

  task automatic b_wait();
    int n = 0;
    while (ifc.bvalid !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) check_eq("b_valid_timeout", ifc.bvalid, 1'b1);
    b_resp = ifc.bresp; b_id = ifc.bid;
    step();
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id);
    aw_send(addr, len, id);
    w_send(int'(len) + 1, int'(len));
    b_wait();
  endtask

  // Collects len+1 beats; with bp set, rready follows 1,0,0,1,0,0,...
  task automatic r_collect(input int len, input bit bp);
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] hd = '0;
    logic hl = 1'b0;
    n_beats = 0; rlast_err = 0; stable_err = 0; rd_lat = 0;
    ifc.rready = 1'b1;
    while (ifc.rvalid !== 1'b1 && rd_lat < 50) begin step(); rd_lat++; end
    first_rid = ifc.rid;
    while (n_beats < len + 1 && cyc < 400) begin
      ifc.rready = bp ? (cyc % 3 == 0) : 1'b1;
      if (ifc.rvalid === 1'b1) begin
        if (held && (ifc.rdata !== hd || ifc.rlast !== hl)) stable_err++;
        if (ifc.rready) begin
          if (n_beats < 16) rd_buf[n_beats] = ifc.rdata;
          if (ifc.rlast !== (n_beats == len)) rlast_err++;
          n_beats++;
          held = 1'b0;
        end else begin
          held = 1'b1; hd = ifc.rdata; hl = ifc.rlast;
        end
      end else if (held) begin
        stable_err++;
      end
      step(); cyc++;
    end
    ifc.rready = 1'b1;
  endtask

  initial begin
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = 3'd2; ifc.awburst = 2'd1;
    ifc.awlock = 1'b0; ifc.awcache = 4'd0; ifc.awprot = 3'd0; ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0; ifc.bready = 1'b1;
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = 3'd2; ifc.arburst = 2'd1;
    ifc.arlock = 1'b0; ifc.arcache = 4'd0; ifc.arprot = 3'd0; ifc.arvalid = 1'b0;
    ifc.rready = 1'b1;
    repeat (3) step();
    check_eq("rst_ctrl", {ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid, ifc.rlast}, 6'b0);
    check_eq("rst_data", {ifc.bid, ifc.rid, ifc.bresp, ifc.rresp, ifc.rdata}, 52'd0);
    reset = 1'b0;
    step();

    // Basic 4-beat write then read-back
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    aw_send(32'h100, 8'd3, 8'h5A);
    check_eq("t1_wready", ifc.wready, 1'b1);
    w_send(4, 3);
    check_eq("t1_bvalid_next", ifc.bvalid, 1'b1);
    check_eq("t1_wready_fall", ifc.wready, 1'b0);
    b_wait();
    check_eq("t1_bresp", b_resp, 2'b00);
    check_eq("t1_bid", b_id, 8'h5A);
    ar_send(32'h100, 8'd3, 8'h3C);
    r_collect(3, 1'b0);
    check_eq("t1_rlat", rd_lat, 2);
    check_eq("t1_rid", first_rid, 8'h3C);
    check_eq("t1_nbeats", n_beats, 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t1_rdata%0d", i), rd_buf[i], 32'(i + 1));
    check_eq("t1_rlast", rlast_err, 0);
    check_eq("t1_rvalid_end", ifc.rvalid, 1'b0);

    // Byte strobes merge into an existing word
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
    write_burst(32'h0, 8'd0, 8'h01);
    wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
    write_burst(32'h0, 8'd0, 8'h02);
    ar_send(32'h0, 8'd0, 8'h03);
    r_collect(0, 1'b0);
    check_eq("t2_strobe", rd_buf[0], 32'hAA22CC44);
    check_eq("t2_rlast", rlast_err, 0);

    // Read backpressure over an 8-beat burst
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'h1000 + 32'(i); wstb[i] = 4'hF; end
    write_burst(32'h400, 8'd7, 8'h04);
    ar_send(32'h400, 8'd7, 8'h05);
    r_collect(7, 1'b1);
    check_eq("t3_nbeats", n_beats, 8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t3_rdata%0d", i), rd_buf[i], 32'h1000 + 32'(i));
    check_eq("t3_rlast", rlast_err, 0);
    check_eq("t3_stable", stable_err, 0);
    check_eq("t3_rvalid_end", ifc.rvalid, 1'b0);

    // wlast on the wrong beat gives SLVERR but both beats land
    wdat[0] = 32'h55; wdat[1] = 32'h66; wstb[0] = 4'hF; wstb[1] = 4'hF;
    aw_send(32'h800, 8'd1, 8'h06);
    w_send(2, 0);
    b_wait();
    check_eq("t5_slverr", b_resp, 2'b10);
    ar_send(32'h800, 8'd1, 8'h07);
    r_collect(1, 1'b0);
    check_eq("t5_err_d0", rd_buf[0], 32'h55);
    check_eq("t5_err_d1", rd_buf[1], 32'h66);

    // Burst starting at the last word wraps to index 0
    wdat[0] = 32'h77; wdat[1] = 32'h88;
    write_burst(32'h3FFC, 8'd1, 8'h08);
    check_eq("t5_wrap_bresp", b_resp, 2'b00);
    ar_send(32'h3FFC, 8'd1, 8'h09);
    r_collect(1, 1'b0);
    check_eq("t5_wrap_d0", rd_buf[0], 32'h77);
    check_eq("t5_wrap_d1", rd_buf[1], 32'h88);
    ar_send(32'h0, 8'd0, 8'h0A);
    r_collect(0, 1'b0);
    check_eq("t5_wrap_idx0", rd_buf[0], 32'h88);

    // Reset arrives on the second beat of a 4-beat write
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    write_burst(32'h200, 8'd3, 8'h0B);
    aw_send(32'h200, 8'd3, 8'h0C);
    wdat[0] = 32'h11;
    w_send(1, 3);
    ifc.wdata = 32'h22; ifc.wstrb = 4'hF; ifc.wvalid = 1'b1; reset = 1'b1;
    step();
    check_eq("t6_rst_ctrl", {ifc.awready, ifc.wready, ifc.arready, ifc.bvalid, ifc.rvalid}, 5'b0);
    reset = 1'b0; ifc.wvalid = 1'b0;
    step();
    ar_send(32'h200, 8'd3, 8'h0D);
    r_collect(3, 1'b0);
    check_eq("t6_beat1", rd_buf[0], 32'h11);
    check_eq("t6_beat3", rd_buf[2], 32'hA2);
    check_eq("t6_beat4", rd_buf[3], 32'hA3);

    // Contention: first goes to write, next to read
    begin
      int n = 0;
      ifc.awaddr = 32'h600; ifc.awlen = 8'd0; ifc.awid = 8'h21; ifc.awvalid = 1'b1;
      ifc.araddr = 32'h400; ifc.arlen = 8'd0; ifc.arid = 8'h22; ifc.arvalid = 1'b1;
      while (ifc.awready !== 1'b1 && ifc.arready !== 1'b1 && n < 50) begin step(); n++; end
      check_eq("t4_c1_awready", ifc.awready, 1'b1);
      check_eq("t4_c1_arready", ifc.arready, 1'b0);
      step();
      ifc.awvalid = 1'b0;
      wdat[0] = 32'hBEEF; wstb[0] = 4'hF;
      w_send(1, 0);
      b_wait();
      check_eq("t4_c1_bid", b_id, 8'h21);
      ar_send(32'h400, 8'd0, 8'h22);
      r_collect(0, 1'b0);
      check_eq("t4_c1_rdata", rd_buf[0], 32'h1000);

      n = 0;
      ifc.awaddr = 32'h604; ifc.awlen = 8'd0; ifc.awid = 8'h23; ifc.awvalid = 1'b1;
      ifc.araddr = 32'h600; ifc.arlen = 8'd0; ifc.arid = 8'h24; ifc.arvalid = 1'b1;
      while (ifc.awready !== 1'b1 && ifc.arready !== 1'b1 && n < 50) begin step(); n++; end
      check_eq("t4_c2_arready", ifc.arready, 1'b1);
      check_eq("t4_c2_awready", ifc.awready, 1'b0);
      step();
      ifc.arvalid = 1'b0;
      r_collect(0, 1'b0);
      check_eq("t4_c2_rdata", rd_buf[0], 32'hBEEF);
      check_eq("t4_c2_rid", first_rid, 8'h24);
      wdat[0] = 32'hCAFE;
      aw_send(32'h604, 8'd0, 8'h23);
      w_send(1, 0);
      b_wait();
      check_eq("t4_c2_bresp", b_resp, 2'b00);
      ar_send(32'h604, 8'd0, 8'h25);
      r_collect(0, 1'b0);
      check_eq("t4_c2_wdata", rd_buf[0], 32'hCAFE);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
